// File: rtl/mod_multiply_seq.sv
// Iterative signed fixed-point multiplier: one multiplier bit per clock, saturating result.
// Optional MUL_ROUND_EN selects round-half-away-from-zero instead of truncation.
module mod_multiply_seq #(
    parameter int W    = 16,
    parameter int FRAC = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [W-1:0]    in_A,
    input  logic [W-1:0]    in_B,
    input  logic            in_En,
    output logic [W-1:0]    out_Out,
    output logic            out_Ready,
    output logic            out_Busy,
    output logic            out_Ovf,
    output logic [FRAC-1:0] out_Frac
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0]    LAST_BIT  = CW'(W - 1);
    localparam logic [2*W-1:0]   POS_LIMIT = ((2*W)'(1) << (W - 1)) - (2*W)'(1);
    localparam logic [2*W-1:0]   NEG_LIMIT = (2*W)'(1) << (W - 1);
    localparam logic [W-1:0]     POS_SAT   = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]     NEG_SAT   = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    magA_q, magA_d;
    logic [W-1:0]    magB_q, magB_d;
    logic            sign_q, sign_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    out_q, out_d;
    logic            ovf_q, ovf_d;
    logic [FRAC-1:0] frac_q, frac_d;

    logic [2*W-1:0]  partial;
    logic [2*W-1:0]  accSum;
    logic [2*W-1:0]  roundedAcc;
    logic [2*W-1:0]  mag;
    logic            satPos;
    logic            satNeg;
    logic [W-1:0]    resVal;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            magA_q  <= '0;
            magB_q  <= '0;
            sign_q  <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            ovf_q   <= 1'b0;
            frac_q  <= '0;
        end else begin
            state_q <= state_d;
            magA_q  <= magA_d;
            magB_q  <= magB_d;
            sign_q  <= sign_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
            frac_q  <= frac_d;
        end
    end

    // accSum is the accumulator value after the current CALC step; the final
    // result is derived from it so it is ready at the CALC->DONE edge.
    always_comb begin
        partial = magB_q[cnt_q] ? ({{W{1'b0}}, magA_q} << cnt_q) : '0;
        accSum  = acc_q + partial;
`ifdef MUL_ROUND_EN
        roundedAcc = accSum + ((2*W)'(1) << (FRAC - 1));
`else
        roundedAcc = accSum;
`endif
        mag    = roundedAcc >> FRAC;
        satPos = !sign_q && (mag > POS_LIMIT);
        satNeg = sign_q && (mag > NEG_LIMIT);
        if (satPos)
            resVal = POS_SAT;
        else if (satNeg)
            resVal = NEG_SAT;
        else if (sign_q)
            resVal = ~mag[W-1:0] + W'(1);
        else
            resVal = mag[W-1:0];
    end

    always_comb begin
        state_d = state_q;
        magA_d  = magA_q;
        magB_d  = magB_q;
        sign_d  = sign_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        ovf_d   = ovf_q;
        frac_d  = frac_q;
        unique case (state_q)
            IDLE: begin
                if (in_En) begin
                    magA_d  = in_A[W-1] ? (~in_A + W'(1)) : in_A;
                    magB_d  = in_B[W-1] ? (~in_B + W'(1)) : in_B;
                    sign_d  = in_A[W-1] ^ in_B[W-1];
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = accSum;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    out_d   = resVal;
                    ovf_d   = satPos || satNeg;
                    frac_d  = accSum[FRAC-1:0];
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign out_Out   = out_q;
    assign out_Ovf   = ovf_q;
    assign out_Frac  = frac_q;
    assign out_Ready = (state_q == DONE);
    assign out_Busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mod_multiply_seq.sv
// Randomised self-checking bench for mod_multiply_seq against an integer-arithmetic model.
// Honours MUL_ROUND_EN the same way the design does.
module tb_mod_multiply_seq;

    localparam int W    = 16;
    localparam int FRAC = 12;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [W-1:0]    in_A = '0;
    logic [W-1:0]    in_B = '0;
    logic            in_En = 1'b0;
    logic [W-1:0]    out_Out;
    logic            out_Ready;
    logic            out_Busy;
    logic            out_Ovf;
    logic [FRAC-1:0] out_Frac;

    int nVectors     = 0;
    int nMiscompares = 0;

    mod_multiply_seq #(.W(W), .FRAC(FRAC)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_A      (in_A),
        .in_B      (in_B),
        .in_En     (in_En),
        .out_Out   (out_Out),
        .out_Ready (out_Ready),
        .out_Busy  (out_Busy),
        .out_Ovf   (out_Ovf),
        .out_Frac  (out_Frac)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nVectors++;
        if (observed !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference: exact signed product, then scale, optional rounding and saturation.
    function automatic void refMul(input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] res, output logic ovf,
                                   output logic [FRAC-1:0] frac);
        longint p, m, q;
        bit     neg;
        p    = longint'($signed(a)) * longint'($signed(b));
        neg  = (p < 0);
        m    = neg ? -p : p;
        frac = FRAC'(m % (longint'(1) << FRAC));
`ifdef MUL_ROUND_EN
        q = (m + (longint'(1) << (FRAC - 1))) >> FRAC;
`else
        q = m >> FRAC;
`endif
        ovf = 1'b0;
        if (!neg && q > (longint'(1) << (W - 1)) - 1) begin
            res = W'((longint'(1) << (W - 1)) - 1);
            ovf = 1'b1;
        end else if (neg && q > (longint'(1) << (W - 1))) begin
            res = W'(longint'(1) << (W - 1));
            ovf = 1'b1;
        end else begin
            res = neg ? W'(-q) : W'(q);
        end
    endfunction

    // One transaction: operands scrambled after acceptance, optional in_En pulse during DONE.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input bit pulseInDone);
        logic [W-1:0]    eRes;
        logic            eOvf;
        logic [FRAC-1:0] eFrac;
        int              lat;
        bit              seen;
        refMul(a, b, eRes, eOvf, eFrac);
        @(negedge clk);
        in_A  = a;
        in_B  = b;
        in_En = 1'b1;
        @(negedge clk);
        in_En = 1'b0;
        in_A  = W'($urandom);
        in_B  = W'($urandom);
        checkOutput("busyAfterAccept", 32'(out_Busy), 32'd1);
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat < 4 * W) begin
            if (out_Ready) seen = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        checkOutput("latency", seen ? 32'(lat) : 32'd0, 32'(W + 1));
        if (seen) begin
            checkOutput("out", 32'(out_Out), 32'(eRes));
            checkOutput("ovf", 32'(out_Ovf), 32'(eOvf));
            checkOutput("frac", 32'(out_Frac), 32'(eFrac));
            checkOutput("busyInDone", 32'(out_Busy), 32'd1);
            if (pulseInDone) in_En = 1'b1;
            @(negedge clk);
            in_En = 1'b0;
            checkOutput("readyOnePulse", 32'(out_Ready), 32'd0);
            checkOutput("idleAfterDone", 32'(out_Busy), 32'd0);
            checkOutput("outHeld", 32'(out_Out), 32'(eRes));
        end
    endtask

    initial begin
        int  t1, t2, n;
        bit  sawReady;
        logic [W-1:0] edgeVals [4];
        logic [W-1:0] ra, rb;
        edgeVals[0] = 16'h8000;
        edgeVals[1] = 16'h7FFF;
        edgeVals[2] = 16'h0000;
        edgeVals[3] = 16'hFFFF;

        #3;
        checkOutput("resetOut", 32'(out_Out), 32'd0);
        checkOutput("resetReady", 32'(out_Ready), 32'd0);
        checkOutput("resetBusy", 32'(out_Busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        applyStimulus(16'h1000, 16'h1000, 1'b0);
        applyStimulus(16'hE800, 16'h2000, 1'b1);
        applyStimulus(16'h3FFF, 16'h3FFF, 1'b0);
        applyStimulus(16'hC001, 16'h3FFF, 1'b1);
        applyStimulus(16'h0800, 16'h0001, 1'b0);
        applyStimulus(16'h8000, 16'h8000, 1'b0);
        applyStimulus(16'h8000, 16'h1000, 1'b0);

        // Abort mid-calculation: outputs must clear asynchronously and no pulse follows.
        @(negedge clk);
        in_A  = 16'h3000;
        in_B  = 16'h2000;
        in_En = 1'b1;
        @(negedge clk);
        in_En = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("abortOut", 32'(out_Out), 32'd0);
        checkOutput("abortOvf", 32'(out_Ovf), 32'd0);
        checkOutput("abortFrac", 32'(out_Frac), 32'd0);
        checkOutput("abortBusy", 32'(out_Busy), 32'd0);
        checkOutput("abortReady", 32'(out_Ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        sawReady = 1'b0;
        repeat (W + 4) begin
            @(negedge clk);
            if (out_Ready) sawReady = 1'b1;
        end
        checkOutput("noReadyAfterAbort", 32'(sawReady), 32'd0);

        // Held in_En restarts immediately; pulse spacing is W+2 cycles.
        @(negedge clk);
        in_A  = 16'h1000;
        in_B  = 16'h2000;
        in_En = 1'b1;
        t1 = -1;
        t2 = -1;
        n  = 0;
        while (t2 < 0 && n < 6 * W) begin
            @(negedge clk);
            n++;
            if (out_Ready) begin
                if (t1 < 0) t1 = n;
                else t2 = n;
            end
        end
        checkOutput("heldPeriod", (t1 >= 0 && t2 >= 0) ? 32'(t2 - t1) : 32'd0, 32'(W + 2));
        checkOutput("heldOut", 32'(out_Out), 32'h2000);
        in_En = 1'b0;
        n = 0;
        while (out_Busy && n < 3 * W) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drainIdle", 32'(out_Busy), 32'd0);

        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 4) == 0) ? edgeVals[$urandom_range(0, 3)] : W'($urandom);
            rb = ($urandom_range(0, 4) == 0) ? edgeVals[$urandom_range(0, 3)] : W'($urandom);
            if ($urandom_range(0, 2) == 0) ra = W'($signed(W'($urandom_range(0, 16'h1FFF))) - 16'sh1000);
            applyStimulus(ra, rb, bit'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
